// File: rtl/ddr_line_writer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_line_writer
// Purpose  : Takes each completed 256-bit line from the line assembler and
//            writes it to DDR3 as one single-beat 32-byte AXI4 write. Line
//            addresses advance linearly through a circular window of
//            DEPTH_LINES lines starting at BASE_ADDR.
// Ports    : axi_clk, rst (async, active high)
//            line_data/line_valid/line_ready  - line input (valid is a pulse)
//            m_aw*, m_w*, m_b*                 - AXI4 write master
//            lines_written                     - count of completed writes
//            overflow, bresp_err               - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module ddr_line_writer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                DEPTH_LINES = 1024,
    parameter int                ID_W        = 4
) (
    input  logic              axi_clk,
    input  logic              rst,
    // line input
    input  logic [255:0]      line_data,
    input  logic              line_valid,
    output logic              line_ready,
    // AXI4 write address channel
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    // AXI4 write data channel
    output logic [255:0]      m_wdata,
    output logic [31:0]       m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    // AXI4 write response channel
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    // status
    output logic [31:0]       lines_written,
    output logic              overflow,
    output logic              bresp_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [ADDR_W-1:0] c_line_bytes = ADDR_W'(32);
    // Address of the last line in the window; the pointer wraps after it.
    localparam logic [ADDR_W-1:0] c_last_addr =
        BASE_ADDR + ADDR_W'((DEPTH_LINES - 1) * 32);

    logic [1:0]        r_state;
    logic              r_line_ready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_ptr;
    logic [255:0]      r_data;
    logic [31:0]       r_lines_written;
    logic              r_overflow;
    logic              r_bresp_err;

    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;

    // Response ID carries no information since every request uses ID 0.
    logic w_unused_bid;
    assign w_unused_bid = ^m_bid;

    assign w_aw_fire     = r_awvalid & m_awready;
    assign w_w_fire      = r_wvalid & m_wready;
    // Done flags including a handshake happening on this edge, so that
    // both channels completing together move straight on to RESP.
    assign w_aw_done_nxt = r_aw_done | w_aw_fire;
    assign w_w_done_nxt  = r_w_done | w_w_fire;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_line_ready    <= 1'b1;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_bready        <= 1'b0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_ptr           <= BASE_ADDR;
            r_data          <= '0;
            r_lines_written <= '0;
            r_overflow      <= 1'b0;
            r_bresp_err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (line_valid) begin
                        r_data       <= line_data;
                        r_awvalid    <= 1'b1;
                        r_wvalid     <= 1'b1;
                        r_line_ready <= 1'b0;
                        r_state      <= c_st_send;
                    end
                end

                c_st_send: begin
                    // Busy: any arriving line is lost.
                    if (line_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= c_st_resp;
                    end else begin
                        r_aw_done <= w_aw_done_nxt;
                        r_w_done  <= w_w_done_nxt;
                    end
                end

                c_st_resp: begin
                    if (line_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (m_bvalid) begin
                        r_bready        <= 1'b0;
                        r_lines_written <= r_lines_written + 32'd1;
                        if (m_bresp != 2'b00) begin
                            r_bresp_err <= 1'b1;
                        end
                        // No retry: the pointer moves on even after an error.
                        if (r_ptr == c_last_addr) begin
                            r_ptr <= BASE_ADDR;
                        end else begin
                            r_ptr <= r_ptr + c_line_bytes;
                        end
                        r_line_ready <= 1'b1;
                        r_state      <= c_st_idle;
                    end
                end

                default: begin
                    r_state      <= c_st_idle;
                    r_line_ready <= 1'b1;
                    r_awvalid    <= 1'b0;
                    r_wvalid     <= 1'b0;
                    r_bready     <= 1'b0;
                    r_aw_done    <= 1'b0;
                    r_w_done     <= 1'b0;
                end
            endcase
        end
    end

    assign line_ready    = r_line_ready;

    assign m_awid        = '0;
    assign m_awaddr      = r_ptr;
    assign m_awlen       = 8'd0;
    assign m_awsize      = 3'b101;
    assign m_awburst     = 2'b01;
    assign m_awvalid     = r_awvalid;

    assign m_wdata       = r_data;
    assign m_wstrb       = '1;
    assign m_wlast       = 1'b1;
    assign m_wvalid      = r_wvalid;

    assign m_bready      = r_bready;

    assign lines_written = r_lines_written;
    assign overflow      = r_overflow;
    assign bresp_err     = r_bresp_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_line_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_line_writer
// Purpose  : Self-checking bench for ddr_line_writer. Plays the AXI slave
//            with programmable handshake delays and compares the DUT with a
//            line-count based model of addresses, counters and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_line_writer;

    localparam int          ADDR_W      = 32;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_1000;
    localparam int          DEPTH_LINES = 4;
    localparam int          ID_W        = 4;

    logic              clk;
    logic              rst;
    logic [255:0]      line_data;
    logic              line_valid;
    logic              line_ready;
    logic [ID_W-1:0]   m_awid;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_awvalid;
    logic              m_awready;
    logic [255:0]      m_wdata;
    logic [31:0]       m_wstrb;
    logic              m_wlast;
    logic              m_wvalid;
    logic              m_wready;
    logic [ID_W-1:0]   m_bid;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [31:0]       lines_written;
    logic              overflow;
    logic              bresp_err;

    ddr_line_writer #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_LINES (DEPTH_LINES),
        .ID_W        (ID_W)
    ) u_dut (
        .axi_clk       (clk),
        .rst           (rst),
        .line_data     (line_data),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .m_awid        (m_awid),
        .m_awaddr      (m_awaddr),
        .m_awlen       (m_awlen),
        .m_awsize      (m_awsize),
        .m_awburst     (m_awburst),
        .m_awvalid     (m_awvalid),
        .m_awready     (m_awready),
        .m_wdata       (m_wdata),
        .m_wstrb       (m_wstrb),
        .m_wlast       (m_wlast),
        .m_wvalid      (m_wvalid),
        .m_wready      (m_wready),
        .m_bid         (m_bid),
        .m_bresp       (m_bresp),
        .m_bvalid      (m_bvalid),
        .m_bready      (m_bready),
        .lines_written (lines_written),
        .overflow      (overflow),
        .bresp_err     (bresp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the address follows purely from how many lines have
    // been acknowledged since reset.
    int          m_line_idx;
    int unsigned m_count;
    bit          m_overflow;
    bit          m_bresp_err;

    function automatic logic [31:0] model_addr();
        return BASE_ADDR + 32'(m_line_idx % DEPTH_LINES) * 32'd32;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_line_ready", line_ready, 1);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_awaddr", m_awaddr, BASE_ADDR);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_lines_written", lines_written, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bresp_err", bresp_err, 0);
    endtask

    // One complete line transfer. Called and returning at a negedge with
    // the DUT idle. aw_dly/w_dly are the cycles each ready is held low,
    // b_dly the cycles before bvalid. dup fires an extra line pulse while
    // the write is in flight; abort resets the DUT while waiting in RESP.
    task automatic send_line(input logic [255:0] d, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] resp, input bit dup,
                             input bit abort);
        bit aw_ok;
        bit w_ok;
        int t;
        logic [31:0] exp_addr;
        exp_addr = model_addr();

        chk("idle_line_ready", line_ready, 1);
        line_data  = d;
        line_valid = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        line_data  = ~d;
        // One edge after the pulse both valids must be up.
        chk("awvalid_rise", m_awvalid, 1);
        chk("wvalid_rise", m_wvalid, 1);
        chk("send_line_ready", line_ready, 0);
        chk("awlen", m_awlen, 0);
        chk("awsize", m_awsize, 3'b101);
        chk("awburst", m_awburst, 2'b01);
        chk("awid", m_awid, 0);
        chk("wstrb", m_wstrb, 32'hFFFF_FFFF);
        chk("wlast", m_wlast, 1);

        aw_ok = 1'b0;
        w_ok  = 1'b0;
        t     = 0;
        while (!(aw_ok && w_ok) && t < 64) begin
            m_awready  = (t >= aw_dly);
            m_wready   = (t >= w_dly);
            line_valid = dup && (t == 0);
            chk("awvalid_hold", m_awvalid, !aw_ok);
            chk("wvalid_hold", m_wvalid, !w_ok);
            chk("bready_send", m_bready, 0);
            if (m_awvalid) chk("awaddr", m_awaddr, exp_addr);
            if (m_wvalid) chk("wdata", m_wdata, d);
            if (m_awvalid && m_awready) aw_ok = 1'b1;
            if (m_wvalid && m_wready) w_ok = 1'b1;
            @(negedge clk);
            t++;
        end
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        line_valid = 1'b0;
        chk("send_timeout", {aw_ok, w_ok}, 2'b11);
        if (dup) m_overflow = 1'b1;

        for (int i = 0; i <= b_dly; i++) begin
            chk("bready_resp", m_bready, 1);
            chk("awvalid_resp", m_awvalid, 0);
            chk("wvalid_resp", m_wvalid, 0);
            chk("resp_line_ready", line_ready, 0);
            if (i < b_dly) @(negedge clk);
        end

        if (abort) begin
            rst = 1'b1;
            #1;
            m_line_idx  = 0;
            m_count     = 0;
            m_overflow  = 1'b0;
            m_bresp_err = 1'b0;
            chk_reset_outputs();
            @(negedge clk);
            rst = 1'b0;
        end else begin
            m_bvalid = 1'b1;
            m_bresp  = resp;
            m_bid    = 4'($urandom);
            @(negedge clk);
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
            m_line_idx++;
            m_count++;
            if (resp != 2'b00) m_bresp_err = 1'b1;
            chk("bready_drop", m_bready, 0);
            chk("line_ready_back", line_ready, 1);
            chk("lines_written", lines_written, m_count);
            chk("bresp_err", bresp_err, m_bresp_err);
            chk("overflow", overflow, m_overflow);
            chk("next_awaddr", m_awaddr, model_addr());
        end
    endtask

    initial begin
        rst        = 1'b1;
        line_data  = '0;
        line_valid = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bid      = '0;
        m_bresp    = 2'b00;
        m_bvalid   = 1'b0;
        m_line_idx  = 0;
        m_count     = 0;
        m_overflow  = 1'b0;
        m_bresp_err = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Single line with all slave readies immediate.
        send_line(256'h0123, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        // W first, AW held off; then the reverse order.
        send_line(rand_line(), 5, 0, 1, 2'b00, 1'b0, 1'b0);
        // Line 3 gets an error response; address must still advance.
        send_line(rand_line(), 0, 5, 0, 2'b10, 1'b0, 1'b0);
        // Extra pulse while busy is dropped and flagged.
        send_line(rand_line(), 2, 3, 2, 2'b00, 1'b1, 1'b0);
        // Fifth line wraps back to the start of the window.
        send_line(rand_line(), 1, 1, 0, 2'b00, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            send_line(rand_line(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 7) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while waiting for a response, then restart from BASE_ADDR.
        send_line(rand_line(), 0, 0, 3, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        send_line(rand_line(), 1, 0, 0, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
